axil_csr_bank: RTL

AXIL_CSR_BANK -- requirements
Module: axil_csr_bank

---
 rtl/axil_csr_pkg.sv | 33 +++
 rtl/axil_csr_irq.sv | 51 +++++
 rtl/axil_csr_bank.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_csr_pkg.sv
//------------------------------------------------------------------------------
// Module : axil_csr_pkg
// Brief  : Shared response codes, FSM states and register-map offsets for the
//          AXI-Lite CSR bank.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axil_csr_pkg;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    // Offsets of the special registers, counted from the end of the RO block
    localparam int c_trig_ofs       = 0;
    localparam int c_irq_status_ofs = 1;
    localparam int c_irq_en_ofs     = 2;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/axil_csr_irq.sv
//------------------------------------------------------------------------------
// Module : axil_csr_irq
// Brief  : W1C interrupt status (set wins over clear), byte-strobed enable and
//          registered level interrupt.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axil_csr_irq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_irq_src,
    input  logic              i_status_we,
    input  logic              i_en_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_wmask,
    output logic [DATA_W-1:0] o_status,
    output logic [DATA_W-1:0] o_en,
    output logic              o_irq
);

    logic [DATA_W-1:0] r_status;
    logic [DATA_W-1:0] r_en;
    logic              r_irq;
    logic [DATA_W-1:0] w_clr;

    assign w_clr = i_status_we ? (i_wdata & i_wmask) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= '0;
            r_en     <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_clr) | i_irq_src;
            if (i_en_we) begin
                r_en <= (r_en & ~i_wmask) | (i_wdata & i_wmask);
            end
            r_irq <= |(r_status & r_en);
        end
    end

    assign o_status = r_status;
    assign o_en     = r_en;
    assign o_irq    = r_irq;

endmodule

`default_nettype wire

// File: rtl/axil_csr_bank.sv
//------------------------------------------------------------------------------
// Module : axil_csr_bank
// Brief  : AXI-Lite CSR bank with RW, RO and trigger registers. Defining
//          AXIL_CSR_IRQ_EN adds the IRQ_STATUS/IRQ_EN registers and irq_o.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axil_csr_bank
    import axil_csr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int N_RW   = 4,
    parameter int N_RO   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      cbus_awaddr,
    input  logic                   cbus_awvalid,
    output logic                   cbus_awready,
    input  logic [DATA_W-1:0]      cbus_wdata,
    input  logic [DATA_W/8-1:0]    cbus_wstrb,
    input  logic                   cbus_wvalid,
    output logic                   cbus_wready,
    output logic [1:0]             cbus_bresp,
    output logic                   cbus_bvalid,
    input  logic                   cbus_bready,
    input  logic [ADDR_W-1:0]      cbus_araddr,
    input  logic                   cbus_arvalid,
    output logic                   cbus_arready,
    output logic [DATA_W-1:0]      cbus_rdata,
    output logic [1:0]             cbus_rresp,
    output logic                   cbus_rvalid,
    input  logic                   cbus_rready,
    output logic [N_RW*DATA_W-1:0] csr_rw_o,
    input  logic [N_RO*DATA_W-1:0] csr_ro_i,
    output logic [DATA_W-1:0]      csr_trig_o
`ifdef AXIL_CSR_IRQ_EN
   ,input  logic [DATA_W-1:0]      irq_src_i,
    output logic                   irq_o
`endif
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [IDX_W-1:0] c_idx_ro     = IDX_W'(N_RW);
    localparam logic [IDX_W-1:0] c_idx_trig   = IDX_W'(N_RW + N_RO + c_trig_ofs);
    localparam logic [IDX_W-1:0] c_idx_irq_st = IDX_W'(N_RW + N_RO + c_irq_status_ofs);
    localparam logic [IDX_W-1:0] c_idx_irq_en = IDX_W'(N_RW + N_RO + c_irq_en_ofs);

    wr_state_t         r_wst;
    wr_state_t         w_wst_nxt;
    rd_state_t         r_rst;
    logic              r_commit, w_commit_nxt;
    logic              r_awready, r_wready, r_bvalid;
    logic              w_awready_nxt, w_wready_nxt;
    logic [1:0]        r_bresp;
    logic [IDX_W-1:0]  r_widx;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [DATA_W-1:0] r_csr [N_RW];
    logic [DATA_W-1:0] r_trig;
    logic              r_arready, r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;

    logic              w_aw_hs, w_w_hs, w_ar_hs;
    logic [DATA_W-1:0] w_wmask;
    logic              w_wr_rw, w_wr_trig, w_wr_irq_st, w_wr_irq_en, w_wr_ok;
    logic [IDX_W-1:0]  w_ridx;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic [1:0]        w_rresp_nxt;
    logic [DATA_W-1:0] w_irq_status, w_irq_en;
    logic              w_unused;

    assign w_unused = ^{cbus_awaddr[1:0], cbus_araddr[1:0]};

    assign w_aw_hs = cbus_awvalid & r_awready;
    assign w_w_hs  = cbus_wvalid  & r_wready;
    assign w_ar_hs = cbus_arvalid & r_arready;

    always_comb begin
        for (int b = 0; b < STRB_W; b++) begin
            w_wmask[8*b +: 8] = {8{r_wstrb[b]}};
        end
    end

    assign w_wr_rw   = (r_widx < c_idx_ro);
    assign w_wr_trig = (r_widx == c_idx_trig);
`ifdef AXIL_CSR_IRQ_EN
    assign w_wr_irq_st = (r_widx == c_idx_irq_st);
    assign w_wr_irq_en = (r_widx == c_idx_irq_en);
`else
    assign w_wr_irq_st = 1'b0;
    assign w_wr_irq_en = 1'b0;
`endif
    assign w_wr_ok = w_wr_rw | w_wr_trig | w_wr_irq_st | w_wr_irq_en;

    // r_commit marks the one cycle between "both channels held" and the update
    always_comb begin
        w_wst_nxt    = r_wst;
        w_commit_nxt = 1'b0;
        case (r_wst)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) w_commit_nxt = 1'b1;
                else if (w_aw_hs)      w_wst_nxt = W_HAVE_AW;
                else if (w_w_hs)       w_wst_nxt = W_HAVE_W;
            end
            W_HAVE_AW: if (w_w_hs)  w_commit_nxt = 1'b1;
            W_HAVE_W:  if (w_aw_hs) w_commit_nxt = 1'b1;
            W_RESP:    if (cbus_bready) w_wst_nxt = W_IDLE;
            default:   w_wst_nxt = W_IDLE;
        endcase
        if (r_commit) w_wst_nxt = W_RESP;
        w_awready_nxt = !w_commit_nxt && (w_wst_nxt == W_IDLE || w_wst_nxt == W_HAVE_W);
        w_wready_nxt  = !w_commit_nxt && (w_wst_nxt == W_IDLE || w_wst_nxt == W_HAVE_AW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wst     <= W_IDLE;
            r_commit  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_resp_okay;
            r_trig    <= '0;
            for (int i = 0; i < N_RW; i++) r_csr[i] <= '0;
        end else begin
            r_wst     <= w_wst_nxt;
            r_commit  <= w_commit_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_trig    <= '0;
            if (w_aw_hs) r_widx <= cbus_awaddr[ADDR_W-1:2];
            if (w_w_hs) begin
                r_wdata <= cbus_wdata;
                r_wstrb <= cbus_wstrb;
            end
            if (r_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? c_resp_okay : c_resp_slverr;
                if (w_wr_trig) r_trig <= r_wdata & w_wmask;
                for (int i = 0; i < N_RW; i++) begin
                    if (r_widx == IDX_W'(i)) r_csr[i] <= (r_csr[i] & ~w_wmask) | (r_wdata & w_wmask);
                end
            end else if (r_bvalid && cbus_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    assign w_ridx = cbus_araddr[ADDR_W-1:2];

    always_comb begin
        w_rdata_nxt = '0;
        w_rresp_nxt = c_resp_slverr;
        for (int i = 0; i < N_RW; i++) begin
            if (w_ridx == IDX_W'(i)) begin
                w_rdata_nxt = r_csr[i];
                w_rresp_nxt = c_resp_okay;
            end
        end
        for (int j = 0; j < N_RO; j++) begin
            if (w_ridx == IDX_W'(N_RW + j)) begin
                w_rdata_nxt = csr_ro_i[j*DATA_W +: DATA_W];
                w_rresp_nxt = c_resp_okay;
            end
        end
`ifdef AXIL_CSR_IRQ_EN
        if (w_ridx == c_idx_irq_st) begin
            w_rdata_nxt = w_irq_status;
            w_rresp_nxt = c_resp_okay;
        end
        if (w_ridx == c_idx_irq_en) begin
            w_rdata_nxt = w_irq_en;
            w_rresp_nxt = c_resp_okay;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst     <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_resp_okay;
        end else begin
            case (r_rst)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_rst     <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rdata_nxt;
                        r_rresp   <= w_rresp_nxt;
                    end
                end
                R_DATA: begin
                    if (cbus_rready) begin
                        r_rst     <= R_IDLE;
                        r_arready <= 1'b1;
                        r_rvalid  <= 1'b0;
                    end
                end
                default: r_rst <= R_IDLE;
            endcase
        end
    end

`ifdef AXIL_CSR_IRQ_EN
    axil_csr_irq #(
        .DATA_W (DATA_W)
    ) u_irq (
        .clk         (clk),
        .rst         (rst),
        .i_irq_src   (irq_src_i),
        .i_status_we (r_commit && w_wr_irq_st),
        .i_en_we     (r_commit && w_wr_irq_en),
        .i_wdata     (r_wdata),
        .i_wmask     (w_wmask),
        .o_status    (w_irq_status),
        .o_en        (w_irq_en),
        .o_irq       (irq_o)
    );
`else
    assign w_irq_status = '0;
    assign w_irq_en     = '0;
`endif

    generate
        for (genvar i = 0; i < N_RW; i++) begin : g_rw
            assign csr_rw_o[i*DATA_W +: DATA_W] = r_csr[i];
        end
    endgenerate

    assign cbus_awready = r_awready;
    assign cbus_wready  = r_wready;
    assign cbus_bvalid  = r_bvalid;
    assign cbus_bresp   = r_bresp;
    assign cbus_arready = r_arready;
    assign cbus_rvalid  = r_rvalid;
    assign cbus_rdata   = r_rdata;
    assign cbus_rresp   = r_rresp;
    assign csr_trig_o   = r_trig;

endmodule

`default_nettype wire
